rob_commit: RTL and testbench

- Reorder buffer: the consumer end of the reservation-station result interface, and the producer of the `rob_clear` flush.
- Allocates one entry per instruction issued by the decoder.
- Captures results broadcast by the RS ALU and by the LSB.
- Retires entries strictly in program order: register writeback, store release, and branch-mispredict flush with redirect PC.

---
 rtl/rob_commit.sv | 207 ++++++++++++++++++++
 tb/tb_rob_commit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
// rob_commit: reorder buffer. Allocates one entry per decoded instruction,
// captures RS ALU / LSB result broadcasts, forwards results to operand
// lookups, and retires strictly in program order (register writeback,
// store release, branch-mispredict flush with redirect PC).
// Ports:
//   clk_in, rst_in (sync active-low), rdy_in (global stall when 0)
//   is_dc/dc_*        : decoder issue (pc, kind 0=reg 1=store 2=branch, rd, pred, alt_pc)
//   rob_tail/rob_full : id of the next allocation / registered back-pressure
//   qi_*/qj_*         : combinational operand lookup with broadcast forwarding
//   is_rs/rs_*, is_lsb/lsb_* : result broadcasts (LSB wins on same id)
//   commit_reg/rd/value/id, commit_store, rob_clear/clear_pc : registered retire pulses
// Optional: define ROB_COMMIT_TRACE_EN to print a line for every commit.
module rob_commit #(
  parameter int unsigned ROB_SIZE = 16,
  parameter int unsigned ROB_W    = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             is_dc,
  input  logic [31:0]      dc_pc,
  input  logic [1:0]       dc_kind,
  input  logic [4:0]       dc_rd,
  input  logic             dc_pred,
  input  logic [31:0]      dc_alt_pc,
  output logic [ROB_W-1:0] rob_tail,
  output logic             rob_full,
  input  logic [ROB_W-1:0] qi_id,
  input  logic [ROB_W-1:0] qj_id,
  output logic             qi_ready,
  output logic             qj_ready,
  output logic [31:0]      qi_value,
  output logic [31:0]      qj_value,
  input  logic             is_rs,
  input  logic [ROB_W-1:0] rs_rob_id,
  input  logic [31:0]      rs_output,
  input  logic             is_lsb,
  input  logic [ROB_W-1:0] lsb_rob_id,
  input  logic [31:0]      lsb_res,
  output logic             commit_reg,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_value,
  output logic [ROB_W-1:0] commit_id,
  output logic             commit_store,
  output logic             rob_clear,
  output logic [31:0]      clear_pc
);

  localparam int unsigned CNT_W = ROB_W + 1;
  localparam logic [1:0] KIND_REG   = 2'd0;
  localparam logic [1:0] KIND_STORE = 2'd1;
  localparam logic [1:0] KIND_BR    = 2'd2;

  logic [ROB_W-1:0]    head, tail;
  logic [CNT_W-1:0]    count;
  logic [ROB_SIZE-1:0] e_valid, e_ready, e_pred;
  logic [1:0]          e_kind   [ROB_SIZE];
  logic [4:0]          e_rd     [ROB_SIZE];
  logic [31:0]         e_alt_pc [ROB_SIZE];
  logic [31:0]         e_value  [ROB_SIZE];

  logic             full_now, alloc, do_commit, rs_cap, lsb_cap, mispred;
  logic [CNT_W-1:0] next_count;

  assign rob_tail = tail;

  // Update enables; the rob_clear cycle discards issue, capture and commit.
  always_comb begin
    full_now   = (count == CNT_W'(ROB_SIZE));
    alloc      = rdy_in && !rob_clear && is_dc && !full_now;
    do_commit  = rdy_in && !rob_clear && (count != '0) && e_valid[head] && e_ready[head];
    rs_cap     = rdy_in && !rob_clear && is_rs && e_valid[rs_rob_id] &&
                 !(alloc && (rs_rob_id == tail));
    lsb_cap    = rdy_in && !rob_clear && is_lsb && e_valid[lsb_rob_id] &&
                 !(alloc && (lsb_rob_id == tail));
    mispred    = (e_kind[head] == KIND_BR) && (e_value[head][0] != e_pred[head]);
    next_count = count + CNT_W'(alloc) - CNT_W'(do_commit);
  end

  // Operand lookup: same-cycle broadcast forwarding, LSB over RS over entry.
  always_comb begin
    qi_ready = e_ready[qi_id];
    qi_value = e_value[qi_id];
    if (is_rs && (rs_rob_id == qi_id)) begin
      qi_ready = 1'b1;
      qi_value = rs_output;
    end
    if (is_lsb && (lsb_rob_id == qi_id)) begin
      qi_ready = 1'b1;
      qi_value = lsb_res;
    end
    qj_ready = e_ready[qj_id];
    qj_value = e_value[qj_id];
    if (is_rs && (rs_rob_id == qj_id)) begin
      qj_ready = 1'b1;
      qj_value = rs_output;
    end
    if (is_lsb && (lsb_rob_id == qj_id)) begin
      qj_ready = 1'b1;
      qj_value = lsb_res;
    end
  end

  // Control state, entry status bits and registered retire outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      e_valid      <= '0;
      e_ready      <= '0;
      rob_full     <= 1'b0;
      commit_reg   <= 1'b0;
      commit_store <= 1'b0;
      rob_clear    <= 1'b0;
      commit_rd    <= '0;
      commit_value <= '0;
      commit_id    <= '0;
      clear_pc     <= '0;
    end else if (rob_clear) begin
      // Flush edge: everything younger than the mispredicted branch is dropped.
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      e_valid      <= '0;
      e_ready      <= '0;
      rob_full     <= 1'b0;
      commit_reg   <= 1'b0;
      commit_store <= 1'b0;
      rob_clear    <= 1'b0;
    end else if (!rdy_in) begin
      commit_reg   <= 1'b0;
      commit_store <= 1'b0;
    end else begin
      commit_reg   <= 1'b0;
      commit_store <= 1'b0;
      if (alloc) begin
        e_valid[tail] <= 1'b1;
        e_ready[tail] <= (dc_kind == KIND_STORE);
        tail          <= tail + ROB_W'(1);
      end
      if (rs_cap)  e_ready[rs_rob_id]  <= 1'b1;
      if (lsb_cap) e_ready[lsb_rob_id] <= 1'b1;
      if (do_commit) begin
        e_valid[head] <= 1'b0;
        e_ready[head] <= 1'b0;
        head          <= head + ROB_W'(1);
        commit_id     <= head;
        case (e_kind[head])
          KIND_REG: begin
            commit_reg   <= 1'b1;
            commit_rd    <= e_rd[head];
            commit_value <= e_value[head];
          end
          KIND_STORE: commit_store <= 1'b1;
          default: begin
            if (mispred) begin
              rob_clear <= 1'b1;
              clear_pc  <= e_alt_pc[head];
            end
          end
        endcase
      end
      count    <= next_count;
      rob_full <= (next_count >= CNT_W'(ROB_SIZE - 1));
    end
  end

  // Entry payload; only meaningful while the entry is valid, so no reset.
  always_ff @(posedge clk_in) begin
    if (alloc) begin
      e_kind[tail]   <= dc_kind;
      e_rd[tail]     <= dc_rd;
      e_pred[tail]   <= dc_pred;
      e_alt_pc[tail] <= dc_alt_pc;
    end
    if (rs_cap)  e_value[rs_rob_id]  <= rs_output;
    if (lsb_cap) e_value[lsb_rob_id] <= lsb_res;
  end

`ifndef SYNTHESIS
  // Issue with a completely full buffer is dropped; flag it in simulation.
  always_ff @(posedge clk_in) begin
    if (rst_in && rdy_in && !rob_clear && is_dc && full_now)
      $display("rob_commit: issue while full ignored (tail=%0d)", tail);
  end
`endif

`ifdef ROB_COMMIT_TRACE_EN
  logic [31:0] e_pc [ROB_SIZE];

  always_ff @(posedge clk_in) begin
    if (alloc) e_pc[tail] <= dc_pc;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in && do_commit)
      $display("rob commit id=%0d pc=%h kind=%0d rd=%0d value=%h%s",
               head, e_pc[head], e_kind[head], e_rd[head], e_value[head],
               mispred ? " MISPRED" : "");
  end
`else
  logic unused_dc_pc;
  assign unused_dc_pc = ^dc_pc;
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Randomized scoreboard bench for rob_commit: a program-order queue model
// predicts retire pulses; a negedge monitor pops and compares them.
module tb_rob_commit;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        is_dc = 1'b1;
  logic [31:0] dc_pc = '0;
  logic [1:0]  dc_kind = '0;
  logic [4:0]  dc_rd = '0;
  logic        dc_pred = 1'b0;
  logic [31:0] dc_alt_pc = '0;
  logic [3:0]  rob_tail;
  logic        rob_full;
  logic [3:0]  qi_id = '0, qj_id = '0;
  logic        qi_ready, qj_ready;
  logic [31:0] qi_value, qj_value;
  logic        is_rs = 1'b1;
  logic [3:0]  rs_rob_id = '0;
  logic [31:0] rs_output = 32'h5;
  logic        is_lsb = 1'b0;
  logic [3:0]  lsb_rob_id = '0;
  logic [31:0] lsb_res = '0;
  logic        commit_reg, commit_store, rob_clear;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value, clear_pc;
  logic [3:0]  commit_id;

  rob_commit #(.ROB_SIZE(16), .ROB_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .is_dc(is_dc), .dc_pc(dc_pc), .dc_kind(dc_kind), .dc_rd(dc_rd),
    .dc_pred(dc_pred), .dc_alt_pc(dc_alt_pc),
    .rob_tail(rob_tail), .rob_full(rob_full),
    .qi_id(qi_id), .qj_id(qj_id), .qi_ready(qi_ready), .qj_ready(qj_ready),
    .qi_value(qi_value), .qj_value(qj_value),
    .is_rs(is_rs), .rs_rob_id(rs_rob_id), .rs_output(rs_output),
    .is_lsb(is_lsb), .lsb_rob_id(lsb_rob_id), .lsb_res(lsb_res),
    .commit_reg(commit_reg), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_id(commit_id), .commit_store(commit_store),
    .rob_clear(rob_clear), .clear_pc(clear_pc)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [3:0]  id;
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic        pred;
    logic [31:0] alt;
    logic        done;
    logic [31:0] val;
  } ent_t;

  // typ: 0 = register writeback, 1 = store release, 2 = flush
  typedef struct {
    int          cyc;
    int          typ;
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] val;
  } exp_t;

  ent_t mq[$];
  exp_t eq[$];
  logic [3:0] m_tail = '0;
  logic       m_full = 1'b0;
  logic       m_flush = 1'b0;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  localparam int NCYC = 3000;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Program-order model: one call per rising edge with the inputs held before it.
  task automatic model_step();
    exp_t x;
    ent_t e;
    bit   com, al;
    if (!rst_in) begin
      mq.delete(); eq.delete();
      m_tail = '0; m_full = 1'b0; m_flush = 1'b0;
      return;
    end
    if (m_flush) begin
      mq.delete();
      m_tail = '0; m_full = 1'b0; m_flush = 1'b0;
      return;
    end
    if (!rdy_in) return;
    com = (mq.size() > 0) && mq[0].done;
    al  = is_dc && (mq.size() < 16);
    for (int i = 0; i < mq.size(); i++) begin
      if (is_rs && mq[i].id == rs_rob_id) begin mq[i].done = 1'b1; mq[i].val = rs_output; end
      if (is_lsb && mq[i].id == lsb_rob_id) begin mq[i].done = 1'b1; mq[i].val = lsb_res; end
    end
    if (com) begin
      e = mq.pop_front();
      x.cyc = cyc; x.id = e.id; x.rd = e.rd; x.val = e.val;
      if (e.kind == 2'd0) begin
        x.typ = 0; eq.push_back(x);
      end else if (e.kind == 2'd1) begin
        x.typ = 1; eq.push_back(x);
      end else if (e.val[0] != e.pred) begin
        x.typ = 2; x.val = e.alt; eq.push_back(x); m_flush = 1'b1;
      end
    end
    if (al) begin
      e.id = m_tail; e.kind = dc_kind; e.rd = dc_rd; e.pred = dc_pred;
      e.alt = dc_alt_pc; e.done = (dc_kind == 2'd1); e.val = '0;
      mq.push_back(e);
      m_tail = m_tail + 4'd1;
    end
    m_full = (mq.size() >= 15);
  endtask

  function automatic bit in_model(input logic [3:0] id);
    foreach (mq[i]) if (mq[i].id == id) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input int n, input bit drain);
    int   pend[$];
    bit   fill;
    int   r, bp;
    fill = (n % 400) < 150;
    rst_in = !(n < 2 || (n >= 1500 && n < 1502));
    rdy_in = drain ? 1'b1 : ($urandom_range(0, 99) >= 12);
    is_dc  = !drain && !m_full && ($urandom_range(0, 99) < (fill ? 85 : 50));
    r = $urandom_range(0, 99);
    if (fill) dc_kind = 2'($urandom_range(0, 1));
    else dc_kind = (r < 55) ? 2'd0 : (r < 75) ? 2'd1 : 2'd2;
    dc_rd = 5'($urandom); dc_pc = $urandom; dc_pred = 1'($urandom); dc_alt_pc = $urandom;
    foreach (mq[i]) if (!mq[i].done) pend.push_back(int'(mq[i].id));
    bp = drain ? 100 : (fill ? 5 : 60);
    is_rs = 1'b0; is_lsb = 1'b0;
    rs_rob_id = 4'($urandom); lsb_rob_id = 4'($urandom);
    rs_output = $urandom; lsb_res = $urandom;
    if (pend.size() > 0 && $urandom_range(0, 99) < bp) begin
      is_rs = 1'b1;
      rs_rob_id = 4'(pend[$urandom_range(0, pend.size() - 1)]);
    end else if ($urandom_range(0, 99) < 8 && !in_model(rs_rob_id)) begin
      is_rs = 1'b1;
    end
    if (pend.size() > 0 && $urandom_range(0, 99) < bp / 2) begin
      is_lsb = 1'b1;
      if (is_rs && $urandom_range(0, 99) < 30 && in_model(rs_rob_id)) lsb_rob_id = rs_rob_id;
      else lsb_rob_id = 4'(pend[$urandom_range(0, pend.size() - 1)]);
    end else if ($urandom_range(0, 99) < 5 && !in_model(lsb_rob_id)) begin
      is_lsb = 1'b1;
    end
    qi_id = ($urandom_range(0, 1) == 1) ? rs_rob_id : 4'($urandom);
    qj_id = ($urandom_range(0, 1) == 1) ? lsb_rob_id : 4'($urandom);
  endtask

  task automatic check_lookup(input string nm, input logic [3:0] q,
                              input logic act_rdy, input logic [31:0] act_val);
    bit r, hv;
    logic [31:0] v;
    r = 1'b0; hv = 1'b0; v = '0;
    if (is_lsb && lsb_rob_id == q) begin r = 1'b1; hv = 1'b1; v = lsb_res; end
    else if (is_rs && rs_rob_id == q) begin r = 1'b1; hv = 1'b1; v = rs_output; end
    else foreach (mq[i]) begin
      if (mq[i].id == q && mq[i].done) begin
        r = 1'b1;
        if (mq[i].kind != 2'd1) begin hv = 1'b1; v = mq[i].val; end
      end
    end
    chk({nm, "_ready"}, 32'(act_rdy), 32'(r));
    if (hv) chk({nm, "_value"}, act_val, v);
  endtask

  // Monitor: every pulse must match the oldest expectation, in the expected cycle.
  always @(negedge clk_in) begin
    exp_t e;
    logic [2:0] pulses, want;
    pulses = {rob_clear, commit_store, commit_reg};
    if (pulses != 3'b000) begin
      if (eq.size() == 0) begin
        chk("unexpected_pulse", 32'(pulses), 32'd0);
      end else begin
        e = eq.pop_front();
        want = 3'b001 << e.typ;
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_kind", 32'(pulses), 32'(want));
        chk("commit_id", 32'(commit_id), 32'(e.id));
        if (e.typ == 0) begin
          chk("commit_rd", 32'(commit_rd), 32'(e.rd));
          chk("commit_value", commit_value, e.val);
        end
        if (e.typ == 2) chk("clear_pc", clear_pc, e.val);
      end
    end else if (eq.size() > 0 && eq[0].cyc <= cyc) begin
      e = eq.pop_front();
      want = 3'b001 << e.typ;
      chk("missing_pulse", 32'(pulses), 32'(want));
    end
    chk("rob_full", 32'(rob_full), 32'(m_full));
    chk("rob_tail", 32'(rob_tail), 32'(m_tail));
    cyc++;
  end

  initial begin
    for (int n = 0; n < NCYC + 80; n++) begin
      @(posedge clk_in);
      model_step();
      #1;
      if (n == 2) begin
        chk("rst_tail", 32'(rob_tail), 32'd0);
        chk("rst_full", 32'(rob_full), 32'd0);
        chk("rst_pulses", 32'({rob_clear, commit_store, commit_reg}), 32'd0);
        chk("rst_commit_id", 32'(commit_id), 32'd0);
        chk("rst_commit_rd", 32'(commit_rd), 32'd0);
        chk("rst_commit_value", commit_value, 32'd0);
        chk("rst_clear_pc", clear_pc, 32'd0);
      end
      #1;
      drive(n, n >= NCYC);
      #1;
      check_lookup("qi", qi_id, qi_ready, qi_value);
      check_lookup("qj", qj_id, qj_ready, qj_value);
    end
    @(posedge clk_in);
    model_step();
    repeat (2) @(negedge clk_in);
    #1;
    chk("leftover_expected", 32'(eq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
